// File: rtl/writeback_arbiter_if.sv
// Result-bus bundle between the three execution units and the writeback arbiter,
// including the common data bus broadcast.
`ifndef ROB_SIZE_BIT
`define ROB_SIZE_BIT 4
`endif

interface writeback_arbiter_if #(
  parameter int unsigned ROB_SIZE_BIT = `ROB_SIZE_BIT
);
  logic                    alu_valid;
  logic                    lsb_valid;
  logic                    mdu_valid;
  logic [ROB_SIZE_BIT-1:0] alu_idx;
  logic [ROB_SIZE_BIT-1:0] lsb_idx;
  logic [ROB_SIZE_BIT-1:0] mdu_idx;
  logic [31:0]             alu_value;
  logic [31:0]             lsb_value;
  logic [31:0]             mdu_value;
  logic                    alu_ready;
  logic                    lsb_ready;
  logic                    mdu_ready;
  logic                    cdb_valid;
  logic [ROB_SIZE_BIT-1:0] cdb_idx;
  logic [31:0]             cdb_value;
  logic [1:0]              cdb_src;

  // Execution units and CDB listeners
  modport master (
    output alu_valid, lsb_valid, mdu_valid,
    output alu_idx, lsb_idx, mdu_idx,
    output alu_value, lsb_value, mdu_value,
    input  alu_ready, lsb_ready, mdu_ready,
    input  cdb_valid, cdb_idx, cdb_value, cdb_src
  );

  // Arbiter side
  modport slave (
    input  alu_valid, lsb_valid, mdu_valid,
    input  alu_idx, lsb_idx, mdu_idx,
    input  alu_value, lsb_value, mdu_value,
    output alu_ready, lsb_ready, mdu_ready,
    output cdb_valid, cdb_idx, cdb_value, cdb_src
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Per-source result FIFOs feeding a round-robin arbiter that drives one registered
// CDB broadcast per cycle (source 0=alu, 1=lsb, 2=mdu).
`ifndef ROB_SIZE_BIT
`define ROB_SIZE_BIT 4
`endif

module writeback_arbiter #(
  parameter int unsigned ROB_SIZE_BIT = `ROB_SIZE_BIT,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               rob_clear,
  writeback_arbiter_if.slave wb
);
  localparam int unsigned NSRC  = 3;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ROB_SIZE_BIT-1:0] mem_idx [NSRC][FIFO_DEPTH];
  logic [31:0]             mem_val [NSRC][FIFO_DEPTH];
  logic [PTR_W-1:0]        head    [NSRC];
  logic [PTR_W-1:0]        tail    [NSRC];
  logic [CNT_W-1:0]        count   [NSRC];
  logic [1:0]              rr_ptr;

  logic                    cdb_valid_q;
  logic [ROB_SIZE_BIT-1:0] cdb_idx_q;
  logic [31:0]             cdb_value_q;
  logic [1:0]              cdb_src_q;

  logic [NSRC-1:0]         in_valid;
  logic [ROB_SIZE_BIT-1:0] in_idx [NSRC];
  logic [31:0]             in_val [NSRC];
  logic [NSRC-1:0]         ready_c;
  logic [NSRC-1:0]         nonempty_c;
  logic [NSRC-1:0]         push_c;
  logic [NSRC-1:0]         pop_c;
  logic                    grant_c;
  logic [1:0]              grant_src_c;

  // Sum of two source numbers reduced mod 3; inputs never exceed 2+2
  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  assign in_valid  = {wb.mdu_valid, wb.lsb_valid, wb.alu_valid};
  assign in_idx[0] = wb.alu_idx;
  assign in_idx[1] = wb.lsb_idx;
  assign in_idx[2] = wb.mdu_idx;
  assign in_val[0] = wb.alu_value;
  assign in_val[1] = wb.lsb_value;
  assign in_val[2] = wb.mdu_value;

  // Ready depends only on the registered occupancy
  always_comb begin
    ready_c    = '0;
    nonempty_c = '0;
    push_c     = '0;
    for (int s = 0; s < NSRC; s++) begin
      ready_c[s]    = count[s] < CNT_W'(FIFO_DEPTH);
      nonempty_c[s] = count[s] != '0;
      push_c[s]     = rdy_in && in_valid[s] && ready_c[s];
    end
  end

  // Round-robin search starting at rr_ptr
  always_comb begin
    grant_c     = 1'b0;
    grant_src_c = 2'd0;
    for (int k = 0; k < NSRC; k++) begin
      if (!grant_c && nonempty_c[wrap3({1'b0, rr_ptr} + 3'(k))]) begin
        grant_c     = 1'b1;
        grant_src_c = wrap3({1'b0, rr_ptr} + 3'(k));
      end
    end
    pop_c = '0;
    for (int s = 0; s < NSRC; s++) begin
      pop_c[s] = rdy_in && grant_c && (grant_src_c == 2'(s));
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int s = 0; s < NSRC; s++) begin
        head[s]  <= '0;
        tail[s]  <= '0;
        count[s] <= '0;
      end
      rr_ptr      <= 2'd0;
      cdb_valid_q <= 1'b0;
      cdb_idx_q   <= '0;
      cdb_value_q <= '0;
      cdb_src_q   <= 2'd0;
    end else if (rob_clear) begin
      // Flush drops queued and same-edge results; last broadcast payload is kept
      for (int s = 0; s < NSRC; s++) begin
        head[s]  <= '0;
        tail[s]  <= '0;
        count[s] <= '0;
      end
      rr_ptr      <= 2'd0;
      cdb_valid_q <= 1'b0;
    end else if (rdy_in) begin
      for (int s = 0; s < NSRC; s++) begin
        if (push_c[s]) begin
          mem_idx[s][tail[s]] <= in_idx[s];
          mem_val[s][tail[s]] <= in_val[s];
          tail[s]             <= tail[s] + PTR_W'(1);
        end
        if (pop_c[s]) begin
          head[s] <= head[s] + PTR_W'(1);
        end
        if (push_c[s] && !pop_c[s]) begin
          count[s] <= count[s] + CNT_W'(1);
        end else if (!push_c[s] && pop_c[s]) begin
          count[s] <= count[s] - CNT_W'(1);
        end
      end
      if (grant_c) begin
        cdb_valid_q <= 1'b1;
        cdb_idx_q   <= mem_idx[grant_src_c][head[grant_src_c]];
        cdb_value_q <= mem_val[grant_src_c][head[grant_src_c]];
        cdb_src_q   <= grant_src_c;
        rr_ptr      <= wrap3({1'b0, grant_src_c} + 3'd1);
      end else begin
        cdb_valid_q <= 1'b0;
      end
    end
  end

  assign wb.alu_ready = ready_c[0];
  assign wb.lsb_ready = ready_c[1];
  assign wb.mdu_ready = ready_c[2];
  assign wb.cdb_valid = cdb_valid_q;
  assign wb.cdb_idx   = cdb_idx_q;
  assign wb.cdb_value = cdb_value_q;
  assign wb.cdb_src   = cdb_src_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reset, latency, contention, fairness,
// backpressure, flush and stall behaviour.
module tb_writeback_arbiter;
  localparam int unsigned RB = 4;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic rob_clear;
  int   errors = 0;
  int   checks = 0;

  writeback_arbiter_if #(.ROB_SIZE_BIT(RB)) wb();

  writeback_arbiter #(.ROB_SIZE_BIT(RB), .FIFO_DEPTH(2)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .rob_clear(rob_clear),
    .wb       (wb.slave)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  // Value tag encodes the source so a misrouted payload is visible
  function automatic logic [31:0] val_of(input int s, input int i);
    return {4'(s + 10), 28'(i)};
  endfunction

  task automatic drive(input int s, input logic v, input logic [RB-1:0] idx, input logic [31:0] val);
    case (s)
      0: begin wb.alu_valid = v; wb.alu_idx = idx; wb.alu_value = val; end
      1: begin wb.lsb_valid = v; wb.lsb_idx = idx; wb.lsb_value = val; end
      default: begin wb.mdu_valid = v; wb.mdu_idx = idx; wb.mdu_value = val; end
    endcase
  endtask

  task automatic idle();
    for (int s = 0; s < 3; s++) drive(s, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    rst_in = 1'b1; rob_clear = 1'b0; rdy_in = 1'b1;
    idle();
    tick(); tick();
    rst_in = 1'b0;
  endtask

  task automatic chk_cdb(input string tag, input logic [RB-1:0] idx, input logic [31:0] val, input logic [1:0] src);
    chk({tag, "_valid"}, 32'(wb.cdb_valid), 32'd1);
    chk({tag, "_idx"},   32'(wb.cdb_idx),   32'(idx));
    chk({tag, "_value"}, wb.cdb_value,      val);
    chk({tag, "_src"},   32'(wb.cdb_src),   32'(src));
  endtask

  int got_a[$], got_l[$], got_m[$];
  int na, nl, nm, mdu_acc, lat;
  logic ra, rl, rm, seen;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_cdb_valid", 32'(wb.cdb_valid), 32'd0);
    chk("rst_cdb_idx",   32'(wb.cdb_idx),   32'd0);
    chk("rst_cdb_value", wb.cdb_value,      32'd0);
    chk("rst_cdb_src",   32'(wb.cdb_src),   32'd0);
    chk("rst_ready",     32'({wb.mdu_ready, wb.lsb_ready, wb.alu_ready}), 32'h7);

    // Single result, two-cycle latency, one-cycle pulse
    drive(0, 1'b1, 4'd5, 32'h1234);
    tick();
    idle();
    chk("single_not_early", 32'(wb.cdb_valid), 32'd0);
    tick();
    chk_cdb("single", 4'd5, 32'h1234, 2'd0);
    tick();
    chk("single_pulse_end", 32'(wb.cdb_valid), 32'd0);
    chk("single_idx_hold",  32'(wb.cdb_idx),   32'd5);

    // Three-way contention from rr_ptr=0
    do_reset();
    drive(0, 1'b1, 4'd1, val_of(0, 1));
    drive(1, 1'b1, 4'd2, val_of(1, 2));
    drive(2, 1'b1, 4'd3, val_of(2, 3));
    tick();
    idle();
    chk("cont_latency", 32'(wb.cdb_valid), 32'd0);
    tick(); chk_cdb("cont0", 4'd1, val_of(0, 1), 2'd0);
    tick(); chk_cdb("cont1", 4'd2, val_of(1, 2), 2'd1);
    tick(); chk_cdb("cont2", 4'd3, val_of(2, 3), 2'd2);
    tick(); chk("cont_drained", 32'(wb.cdb_valid), 32'd0);

    // Fairness: alu streams continuously, mdu pushes once
    do_reset();
    na = 0; ra = 1'b0; rm = 1'b0; mdu_acc = -1; lat = -1; seen = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (wb.cdb_valid && wb.cdb_src == 2'd2 && !seen) begin
        seen = 1'b1;
        lat  = c - mdu_acc;
        chk("fair_mdu_idx", 32'(wb.cdb_idx), 32'd9);
      end
      if (wb.alu_valid && ra) na++;
      if (wb.mdu_valid && rm) mdu_acc = c;
      drive(0, 1'b1, 4'(na), val_of(0, na));
      if (c == 3) drive(2, 1'b1, 4'd9, val_of(2, 9));
      else if (mdu_acc >= 0) drive(2, 1'b0, '0, '0);
      ra = wb.alu_ready; rm = wb.mdu_ready;
      tick();
    end
    idle();
    chk("fair_seen",    32'(seen), 32'd1);
    chk("fair_lat_le3", 32'(lat >= 1 && lat <= 3), 32'd1);

    // Backpressure: lsb sends 3 while alu/mdu saturate
    do_reset();
    na = 0; nl = 0; nm = 0; ra = 1'b0; rl = 1'b0; rm = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (wb.cdb_valid) begin
        chk("bp_value", wb.cdb_value, val_of(int'(wb.cdb_src), int'(wb.cdb_idx)));
        case (wb.cdb_src)
          2'd0:    got_a.push_back(int'(wb.cdb_idx));
          2'd1:    got_l.push_back(int'(wb.cdb_idx));
          default: got_m.push_back(int'(wb.cdb_idx));
        endcase
      end
      if (wb.alu_valid && ra) na++;
      if (wb.lsb_valid && rl) nl++;
      if (wb.mdu_valid && rm) nm++;
      if (c == 2) chk("bp_lsb_ready_full", 32'(wb.lsb_ready), 32'd0);
      drive(0, na < 6, 4'(na), val_of(0, na));
      drive(1, nl < 3, 4'(nl), val_of(1, nl));
      drive(2, nm < 6, 4'(nm), val_of(2, nm));
      ra = wb.alu_ready; rl = wb.lsb_ready; rm = wb.mdu_ready;
      tick();
    end
    idle();
    chk("bp_alu_count", 32'(got_a.size()), 32'd6);
    chk("bp_lsb_count", 32'(got_l.size()), 32'd3);
    chk("bp_mdu_count", 32'(got_m.size()), 32'd6);
    foreach (got_a[i]) chk("bp_alu_order", 32'(got_a[i]), 32'(i));
    foreach (got_l[i]) chk("bp_lsb_order", 32'(got_l[i]), 32'(i));
    foreach (got_m[i]) chk("bp_mdu_order", 32'(got_m[i]), 32'(i));

    // Flush with two entries per source and a same-edge alu push
    do_reset();
    for (int s = 0; s < 3; s++) drive(s, 1'b1, 4'd0, val_of(s, 0));
    tick();
    for (int s = 0; s < 3; s++) drive(s, 1'b1, 4'd1, val_of(s, 1));
    tick();
    chk_cdb("flush_pre", 4'd0, val_of(0, 0), 2'd0);
    idle();
    rob_clear = 1'b1;
    drive(0, 1'b1, 4'd7, val_of(0, 7));
    tick();
    rob_clear = 1'b0;
    idle();
    chk("flush_cdb_valid", 32'(wb.cdb_valid), 32'd0);
    chk("flush_ready", 32'({wb.mdu_ready, wb.lsb_ready, wb.alu_ready}), 32'h7);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("flush_no_stale", 32'(wb.cdb_valid), 32'd0);
    end

    // Stall: rdy_in low for 3 cycles with a live broadcast and queued work
    do_reset();
    drive(0, 1'b1, 4'd0, val_of(0, 0));
    drive(1, 1'b1, 4'd0, val_of(1, 0));
    tick();
    drive(0, 1'b1, 4'd1, val_of(0, 1));
    drive(1, 1'b0, '0, '0);
    tick();
    idle();
    chk_cdb("stall_pre", 4'd0, val_of(0, 0), 2'd0);
    rdy_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_cdb("stall_hold", 4'd0, val_of(0, 0), 2'd0);
    end
    rdy_in = 1'b1;
    tick(); chk_cdb("stall_res0", 4'd0, val_of(1, 0), 2'd1);
    tick(); chk_cdb("stall_res1", 4'd1, val_of(0, 1), 2'd0);
    tick(); chk("stall_drained", 32'(wb.cdb_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter ROB_SIZE_BIT, default from config.v (`ROB_SIZE_BIT), width of ROB index fields.
REQ-002 Parameter FIFO_DEPTH, default 2, entries per source queue; legal values 2 or 4.
REQ-003 clk_in  input  1  system clock; single clock domain, all state updates on rising edge.
REQ-004 rst_in  input  1  synchronous active-high reset.
REQ-005 rdy_in  input  1  global ready; low = hold all state.
REQ-006 rob_clear  input  1  misprediction flush.
REQ-007 alu_valid / lsb_valid / mdu_valid  input  1 each  source result valid.
REQ-008 alu_idx / lsb_idx / mdu_idx  input  ROB_SIZE_BIT each  result ROB index.
REQ-009 alu_value / lsb_value / mdu_value  input  32 each  result value.
REQ-010 alu_ready / lsb_ready / mdu_ready  output  1 each  source queue can accept.
REQ-011 cdb_valid  output  1  broadcast valid (to RS, LSB, ROB).
REQ-012 cdb_idx  output  ROB_SIZE_BIT  broadcast ROB index.
REQ-013 cdb_value  output  32  broadcast value.
REQ-014 cdb_src  output  2  granted source: 0=alu, 1=lsb, 2=mdu.

Function
REQ-015 Each source SHALL own a FIFO_DEPTH-entry FIFO of {idx, value} with head/tail pointers wrapping mod FIFO_DEPTH and an occupancy counter.
REQ-016 src_ready SHALL equal (count < FIFO_DEPTH), driven from registered count only; no combinational path from valid or pop.
REQ-017 Push SHALL occur on an edge with rdy_in && src_valid && src_ready; valid while not ready is dropped-by-contract (source must hold).
REQ-018 Arbitration candidates SHALL be non-empty FIFO heads; one grant per cycle.
REQ-019 Grant SHALL be round-robin: search order starts at rr_ptr, ascending mod 3; after a grant, rr_ptr <= (granted + 1) mod 3; no grant = rr_ptr unchanged.
REQ-020 On grant, head SHALL pop and cdb_valid/idx/value/src SHALL register the head at the same edge; with no candidate, cdb_valid <= 0 and idx/value/src hold.
REQ-021 Latency: result accepted at edge n (empty queues, no contention) SHALL appear with cdb_valid high during the cycle after edge n+1 (2 cycles); cdb_valid high for exactly one cycle per result.
REQ-022 Simultaneous push and pop on same FIFO SHALL leave count unchanged and preserve order; push to a full FIFO never occurs because ready is low.
REQ-023 Per-source order SHALL be preserved; no result duplicated or lost except by flush.
REQ-024 Starvation bound: a non-empty head SHALL be granted within 3 cycles.
REQ-025 rdy_in low SHALL freeze all FIFOs, counters, rr_ptr and cdb_* registers (cdb_valid holds its value).
REQ-026 rob_clear high (rdy_in irrelevant) SHALL at the edge empty all FIFOs, set cdb_valid <= 0, rr_ptr <= 0; same-edge pushes discarded; rob_clear has priority over rdy_in.
REQ-027 Count arithmetic SHALL use clog2(FIFO_DEPTH)+1 bits; rr_ptr 2 bits, never 3.

Reset
REQ-028 On rst_in high at an edge: all FIFO counts, pointers = 0; rr_ptr = 0; cdb_valid = 0, cdb_idx = 0, cdb_value = 0, cdb_src = 0; all src_ready = 1 after the edge.
REQ-029 rst_in SHALL override rob_clear and rdy_in; reset mid-traffic discards all queued results.

Verification
REQ-030 Single: alu push idx=5 value=0x1234 at edge 1 -> cdb_valid=1, idx=5, value=0x1234, src=0 after edge 2 only; low after edge 3.
REQ-031 Contention: alu/lsb/mdu push idx 1/2/3 same edge, rr_ptr=0 -> cdb order idx 1,2,3 on three consecutive cycles, src 0,1,2.
REQ-032 Fairness: alu pushes every cycle, mdu pushes once -> mdu result broadcast within 3 cycles of entering its FIFO.
REQ-033 Backpressure: lsb pushes 3 with DEPTH=2 while alu/mdu saturate -> lsb_ready low at count 2, no loss, lsb order preserved.
REQ-034 Flush: two entries queued per source, rob_clear pulse plus alu push same edge -> cdb_valid=0 next cycle, all ready=1, no stale broadcast afterwards.
REQ-035 Stall: rdy_in low 3 cycles with cdb_valid=1 and queued entries -> cdb_* unchanged, no pop; sequence resumes identically when rdy_in returns.
